// File: rtl/cordic_sweep_seq.sv
// cordic_sweep_seq: walks a 5-degree angle index across a sweep, holds it on
// the CORDIC engine's z0 input until a result is trusted (guarded done pulse
// or forced timeout), captures cos/sin and streams each sample out on a
// valid/ready interface tagged with its index. Single-pass or wrap-around.
module cordic_sweep_seq #(
    parameter int IDX_MAX     = 71,
    parameter int WAIT_CYCLES = 28,
    parameter int DONE_GUARD  = 14
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [6:0]         step,
    input  logic               cont,
    output logic [6:0]         cordic_z0,
    input  logic signed [15:0] cordic_cos,
    input  logic signed [15:0] cordic_sin,
    input  logic               cordic_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         out_index,
    output logic signed [15:0] out_cos,
    output logic signed [15:0] out_sin,
    output logic               busy,
    output logic               sweep_done
);

    localparam logic [4:0] LP_WAIT_LAST = 5'(WAIT_CYCLES - 1);
    localparam logic [4:0] LP_GUARD     = 5'(DONE_GUARD);
    localparam logic [7:0] LP_IDX_MAX   = 8'(IDX_MAX);
    localparam logic [7:0] LP_WRAP      = 8'(IDX_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [6:0]          r_idx;
    logic [6:0]          r_z0;
    logic [4:0]          r_cnt;
    logic [6:0]          r_step;
    logic                r_cont;
    logic                r_out_valid;
    logic [6:0]          r_out_index;
    logic signed [15:0]  r_out_cos;
    logic signed [15:0]  r_out_sin;
    logic                r_busy;
    logic                r_sweep_done;

    logic                w_accept;
    logic                w_capture;
    logic                w_advance;
    logic                w_finish;
    logic [7:0]          w_sum;
    logic [7:0]          w_wrap;
    logic [6:0]          w_idx_nxt;

    assign cordic_z0  = r_z0;
    assign out_valid  = r_out_valid;
    assign out_index  = r_out_index;
    assign out_cos    = r_out_cos;
    assign out_sin    = r_out_sin;
    assign busy       = r_busy;
    assign sweep_done = r_sweep_done;

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control decisions; stop beats everything
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        // 8-bit sum so an overshoot past IDX_MAX is visible before wrapping
        w_sum       = {1'b0, r_idx} + {1'b0, r_step};
        w_wrap      = w_sum - LP_WRAP;
        w_idx_nxt   = (w_sum <= LP_IDX_MAX) ? w_sum[6:0] : w_wrap[6:0];
        if (stop) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = SETTLE;
                    end
                end
                SETTLE: begin
                    // early done pulses may belong to the previous angle
                    if ((cordic_done && r_cnt >= LP_GUARD) || r_cnt == LP_WAIT_LAST) begin
                        w_capture   = 1'b1;
                        w_state_nxt = OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (r_out_valid && out_ready) begin
                        if (w_sum <= LP_IDX_MAX || r_cont) begin
                            w_advance   = 1'b1;
                            w_state_nxt = SETTLE;
                        end else begin
                            w_finish    = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: sweep parameters, settle counter, captured sample, status
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_z0         <= '0;
            r_cnt        <= '0;
            r_step       <= 7'd1;
            r_cont       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_index  <= '0;
            r_out_cos    <= '0;
            r_out_sin    <= '0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            if (stop) begin
                // captured sample is kept for inspection after an abort
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_step <= (step == 7'd0) ? 7'd1 : step;
                    r_cont <= cont;
                    r_idx  <= '0;
                    r_z0   <= '0;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                end
                if (r_state == SETTLE && !w_capture && r_cnt != LP_WAIT_LAST)
                    r_cnt <= r_cnt + 5'd1;
                if (w_capture) begin
                    r_out_cos   <= cordic_cos;
                    r_out_sin   <= cordic_sin;
                    r_out_index <= r_idx;
                    r_out_valid <= 1'b1;
                end
                if (w_advance) begin
                    r_idx       <= w_idx_nxt;
                    r_z0        <= w_idx_nxt;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                end
                if (w_finish) begin
                    // z0 deliberately left on the last angle
                    r_out_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_sweep_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/cordic_sweep_seq.md
# cordic_sweep_seq

Upstream sequencer for the CORDIC sine/cosine engine. It walks the 7-bit angle index (5° per LSB, 0..71 = 0°..355°) across a sweep, holds each index on the engine's `z0` input until a result is valid, and captures `cos`/`sin`. Each sample goes out on a valid/ready stream tagged with its index. It supports single-pass and continuous (wrap-around) sweeps with a programmable step.

## Interface

Parameters:

- `IDX_MAX`, default 71: last legal angle index.
- `WAIT_CYCLES`, default 28: forced-capture point. Two engine periods (14 cycles each) after `z0` changes.
- `DONE_GUARD`, default 14: `cordic_done` is ignored until this many cycles after a `z0` change, so stale results are rejected.

Ports:

- `CLK` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a sweep. Ignored while `busy`.
- `stop` in 1: abort. Takes effect at the next edge and overrides `start`.
- `step` in 7: index increment, sampled on `start`. A value of 0 is treated as 1.
- `cont` in 1: selects continuous wrap mode. Sampled on `start`.
- `cordic_z0` out 7: angle index driven to the engine.
- `cordic_cos` in 16 signed: engine result.
- `cordic_sin` in 16 signed: engine result.
- `cordic_done` in 1: engine result-valid pulse.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: downstream can accept.
- `out_index` out 7: angle index of the current sample.
- `out_cos` out 16 signed: captured cosine.
- `out_sin` out 16 signed: captured sine.
- `busy` out 1: high from the edge that accepts `start` until return to IDLE.
- `sweep_done` out 1: one-cycle pulse when a single-pass sweep completes.

## Operation

- States: IDLE, SETTLE, OUTPUT.
- **IDLE**:
  - `start && !stop` loads `step_r` (0→1) and `cont_r`.
  - Sets `idx=0` and `cordic_z0=0`, clears `cnt`, asserts `busy`, and enters SETTLE.
- **SETTLE**:
  - `cnt` increments each cycle. `cordic_z0` is held constant.
  - Capture occurs when `(cordic_done && cnt >= DONE_GUARD) || cnt == WAIT_CYCLES-1`.
  - At the capture edge, `cordic_cos`/`cordic_sin` are registered into `out_cos`/`out_sin` and `out_index <= idx`. `out_valid` rises at the same edge. Enter OUTPUT.
- **OUTPUT**:
  - `out_valid`, `out_index`, `out_cos` and `out_sin` are held stable until `out_valid && out_ready`.
  - On the handshake edge:
    - Compute `nxt = {1'b0,idx} + step_r` as an 8-bit sum.
    - If `nxt <= IDX_MAX`: `idx <= nxt`, `cordic_z0 <= nxt`, `cnt <= 0`, `out_valid <= 0`, go to SETTLE.
    - Else if `cont_r`: `idx <= nxt - (IDX_MAX+1)` (wrap), then the same transition to SETTLE.
    - Else: `out_valid <= 0`, `busy <= 0`, `sweep_done <= 1` for one cycle, go to IDLE. `cordic_z0` keeps its last value.
- **stop**: from any state, the next edge goes to IDLE with `out_valid=0`, `busy=0`, and no `sweep_done`. `out_cos`/`out_sin`/`out_index` retain their values.
- `cordic_done` outside SETTLE is ignored. So is `cordic_done` with `cnt < DONE_GUARD`.
- `cnt` is 5 bits and saturates at `WAIT_CYCLES-1`. It cannot wrap.
- The captured data is the raw engine output. No scaling or sign correction is applied here.

## Timing

- Reset (asynchronous, `reset_n=0`): state IDLE, `cordic_z0=0`, `out_valid=0`, `out_index=0`, `out_cos=0`, `out_sin=0`, `busy=0`, `sweep_done=0`, `cnt=0`, `step_r=1`, `cont_r=0`.
- Release is synchronous to the next `CLK` edge. Reset mid-sweep discards everything.
- `start` sampled at edge T: `busy=1` and `cordic_z0=0` are visible after T. `cnt=0` in the cycle after T.
- Worst-case latency from a `z0` change to `out_valid`: `WAIT_CYCLES` edges (28). Earliest: `DONE_GUARD+1` edges (15), when `cordic_done` arrives with `cnt=DONE_GUARD`.
- With `out_ready` tied high, the per-sample period is latency + 1 cycle (the OUTPUT cycle).
- `start` coincident with a handshake or while `busy` is ignored.
- `stop` and `start` in the same IDLE cycle: stays in IDLE.

## Test plan

- **Single sweep with forced capture.** `step=18`, `cont=0`, `cordic_done` held 0, `out_ready=1`.
  - Expect `out_index` 0, 18, 36, 54.
  - Each `out_valid` arrives exactly 28 cycles after its `cordic_z0` change.
  - Then a `sweep_done` pulse and `busy=0`.
- **Guarded done.** Pulse `cordic_done` at cnt=5 and again at cnt=14, with `cordic_cos=155`, `cordic_sin=-3`.
  - The cnt=5 pulse is ignored.
  - Capture happens on the cnt=14 pulse: `out_cos=155`, `out_sin=-3`, `out_valid` 15 cycles after the `z0` change.
- **Backpressure.** `out_ready=0` for 10 cycles after `out_valid`; change `cordic_cos` meanwhile.
  - `out_cos`, `out_index` and `cordic_z0` stay stable.
  - Advance occurs exactly on the first cycle with `out_ready=1`.
- **Wrap-around.** `step=30`, `cont=1`.
  - `out_index` sequence 0, 30, 60, 18, 48, 6, …
  - No `sweep_done`. `busy` stays 1.
- **Step 0 and edge indices.** `step=0`, `cont=0`.
  - Expect 72 samples with `out_index` 0..71, then `sweep_done`.
  - `start` pulsed mid-sweep has no effect.
- **Abort and reset.**
  - `stop` during OUTPUT: next edge gives `out_valid=0`, `busy=0`, no `sweep_done`.
  - Separately, assert `reset_n=0` asynchronously mid-SETTLE: all outputs read 0 immediately, without waiting for a `CLK` edge.
